// File: rtl/sna_flit_unboxer_q.sv
// sna_flit_unboxer_q
//   NoC-side flit unboxer for the NoC-to-AXI4-Lite bridge. Typed flits from
//   the router port are reassembled into complete requests (write = head +
//   tail, read = single flit) and queued in a request FIFO for the AXI4-Lite
//   master. Protocol violations produce a registered one-cycle proto_err.
//
// Optional feature macro: SNA_UNBOXER_ERR_CNT_EN
//   When defined, adds the 16-bit saturating err_count output.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   noc_valid/noc_flit/noc_ready   flit input handshake
//   req_valid/req_ready       request FIFO head handshake
//   req_addr/data/read/src    FIFO head request fields (0 when empty)
//   proto_err                 one-cycle violation pulse
//   err_count                 (optional) saturating violation counter
module sna_flit_unboxer_q #(
  parameter int DATA_W    = 32,
  parameter int SRC_W     = 2,
  parameter int FLIT_W    = DATA_W + SRC_W + 3,
  parameter int REQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              noc_valid,
  input  logic [FLIT_W-1:0] noc_flit,
  output logic              noc_ready,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [DATA_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_data,
  output logic              req_read,
  output logic [SRC_W-1:0]  req_src,
  output logic              proto_err
`ifdef SNA_UNBOXER_ERR_CNT_EN
  ,
  output logic [15:0]       err_count
`endif
);

  localparam int AW    = $clog2(REQ_DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HEAD = 1'b1;

  localparam logic [1:0] T_BODY   = 2'b00;
  localparam logic [1:0] T_TAIL   = 2'b01;
  localparam logic [1:0] T_HEAD   = 2'b10;
  localparam logic [1:0] T_SINGLE = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              read;
    logic [SRC_W-1:0]  src;
  } req_t;

  // flit field decode
  logic [1:0]        f_type;
  logic              f_rd;
  logic [SRC_W-1:0]  f_src;
  logic [DATA_W-1:0] f_pl;
  assign f_type = noc_flit[FLIT_W-1:FLIT_W-2];
  assign f_rd   = noc_flit[FLIT_W-3];
  assign f_src  = noc_flit[FLIT_W-4:DATA_W];
  assign f_pl   = noc_flit[DATA_W-1:0];

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] hd_addr_q, hd_addr_d;
  logic [SRC_W-1:0]  hd_src_q, hd_src_d;
  logic              err_q, err_d;
  logic              push_d;
  req_t              push_req;

  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q;
  req_t              mem_q [REQ_DEPTH];

  logic fire, push, pop, fifo_empty;

  assign noc_ready  = (cnt_q != CNT_W'(REQ_DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign fire       = noc_valid && noc_ready;
  assign push       = fire && push_d;
  assign pop        = req_valid && req_ready;

  // Assembler next state. Decisions only take effect on a flit fire.
  always_comb begin
    state_d   = state_q;
    hd_addr_d = hd_addr_q;
    hd_src_d  = hd_src_q;
    err_d     = 1'b0;
    push_d    = 1'b0;
    push_req  = '{addr: f_pl, data: '0, read: 1'b1, src: f_src};
    if (fire) begin
      if (state_q == ST_IDLE) begin
        if (f_type == T_HEAD && !f_rd) begin
          hd_addr_d = f_pl;
          hd_src_d  = f_src;
          state_d   = ST_HEAD;
        end else if (f_type == T_SINGLE && f_rd) begin
          push_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        case (f_type)
          T_TAIL: begin
            push_d   = 1'b1;
            push_req = '{addr: hd_addr_q, data: f_pl, read: 1'b0, src: hd_src_q};
            err_d    = (f_src != hd_src_q);
            state_d  = ST_IDLE;
          end
          T_HEAD: begin
            err_d = 1'b1;
            // a new write head replaces the pending one; a read head is junk
            if (!f_rd) begin
              hd_addr_d = f_pl;
              hd_src_d  = f_src;
            end
          end
          T_SINGLE: begin
            err_d = 1'b1;
            // a read single completes on its own and abandons the pending head
            if (f_rd) begin
              push_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
          default: err_d = 1'b1; // body flits are never legal
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hd_addr_q <= '0;
      hd_src_q  <= '0;
      err_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hd_addr_q <= hd_addr_d;
      hd_src_q  <= hd_src_d;
      err_q     <= err_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // storage needs no reset: outputs are masked while the FIFO is empty
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_req;
  end

  req_t head;
  assign head      = fifo_empty ? req_t'('0) : mem_q[rd_ptr_q];
  assign req_valid = !fifo_empty;
  assign req_addr  = head.addr;
  assign req_data  = head.data;
  assign req_read  = head.read;
  assign req_src   = head.src;
  assign proto_err = err_q;

`ifdef SNA_UNBOXER_ERR_CNT_EN
  logic [15:0] err_cnt_q;
  always_ff @(posedge clk) begin
    if (rst)                               err_cnt_q <= '0;
    else if (err_q && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign err_count = err_cnt_q;
`endif

endmodule
